// File: rtl/capture_buffer_pkg.sv
// Shared mode constants and sizing helper for the capture buffer.
package capture_buffer_pkg;

  // Capture strobe interpretation
  localparam int unsigned EDGE_LEVEL  = 0;
  localparam int unsigned EDGE_RISING = 1;

  // Behaviour when a capture arrives while full
  localparam int unsigned OVF_DROP      = 0;
  localparam int unsigned OVF_OVERWRITE = 1;

  // Bits needed to hold a count from 0 to depth inclusive
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/strobe_edge_detect.sv
// Rising-edge detector for the capture strobe. A strobe already high when
// reset releases is not treated as an edge; it must be seen low first.
module strobe_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic r_in_q;
  logic r_armed;

  // Delayed copy of the strobe plus an arm flag set once the strobe is seen low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_q  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_in_q <= in;
      if (!in) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign pulse = in & ~r_in_q & r_armed;

endmodule

// File: rtl/capture_buffer.sv
// Small FIFO that records data on a capture strobe and hands it out on pop.
module capture_buffer
  import capture_buffer_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned EDGE_MODE = EDGE_RISING,
  parameter int unsigned OVERWRITE = OVF_DROP
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ck,
  input  logic [WIDTH-1:0]              data,
  input  logic                          rd,
  input  logic                          clr_ovf,
  output logic [WIDTH-1:0]              out,
  output logic                          valid,
  output logic                          full,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = count_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic [PW-1:0]    w_rd_ptr_nxt;
  logic [PW-1:0]    w_wr_ptr_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic             w_overflow_nxt;
  logic             w_ovf_set;
  logic             w_we;
  logic             w_cap;
  logic             w_pop;
  logic             w_valid;
  logic             w_full;

  // Capture event source: rising edge of ck or ck level
  generate
    if (EDGE_MODE == EDGE_RISING) begin : g_edge
      strobe_edge_detect u_edge (
        .clk   (clk),
        .rst   (rst),
        .in    (ck),
        .pulse (w_cap)
      );
    end else begin : g_level
      assign w_cap = ck;
    end
  endgenerate

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = rd & w_valid;

  // Next-state for pointers, count and overflow flag
  always_comb begin
    w_rd_ptr_nxt   = r_rd_ptr;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_count_nxt    = r_count;
    w_we           = 1'b0;
    w_ovf_set      = 1'b0;
    if (w_cap) begin
      if (w_pop) begin
        // When full, wr_ptr == rd_ptr: the write lands in the slot being popped
        w_we         = 1'b1;
        w_wr_ptr_nxt = r_wr_ptr + PW'(1);
        w_rd_ptr_nxt = r_rd_ptr + PW'(1);
      end else if (!w_full) begin
        w_we         = 1'b1;
        w_wr_ptr_nxt = r_wr_ptr + PW'(1);
        w_count_nxt  = r_count + CW'(1);
      end else begin
        w_ovf_set = 1'b1;
        if (OVERWRITE == OVF_OVERWRITE) begin
          w_we         = 1'b1;
          w_wr_ptr_nxt = r_wr_ptr + PW'(1);
          w_rd_ptr_nxt = r_rd_ptr + PW'(1);
        end
      end
    end else if (w_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + PW'(1);
      w_count_nxt  = r_count - CW'(1);
    end
    w_overflow_nxt = w_ovf_set | (r_overflow & ~clr_ovf);
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_count    <= w_count_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  // Entry storage as a flop array
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_we) begin
      r_mem[r_wr_ptr] <= data;
    end
  end

  assign out      = w_valid ? r_mem[r_rd_ptr] : '0;
  assign valid    = w_valid;
  assign full     = w_full;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_capture_buffer.sv
// Directed bench for capture_buffer: default, overwrite and level-mode instances.
module tb_capture_buffer;

  logic       clk;
  logic       rst;
  logic       ck;
  logic [3:0] data;
  logic       rd;
  logic       clr_ovf;

  logic [3:0] out_d, out_o, out_l;
  logic       valid_d, valid_o, valid_l;
  logic       full_d, full_o, full_l;
  logic [2:0] count_d, count_o, count_l;
  logic       ovf_d, ovf_o, ovf_l;

  int checks;
  int failures;

  capture_buffer dut (
    .clk(clk), .rst(rst), .ck(ck), .data(data), .rd(rd), .clr_ovf(clr_ovf),
    .out(out_d), .valid(valid_d), .full(full_d), .count(count_d), .overflow(ovf_d)
  );

  capture_buffer #(.OVERWRITE(1)) dut_ow (
    .clk(clk), .rst(rst), .ck(ck), .data(data), .rd(rd), .clr_ovf(clr_ovf),
    .out(out_o), .valid(valid_o), .full(full_o), .count(count_o), .overflow(ovf_o)
  );

  capture_buffer #(.EDGE_MODE(0)) dut_lv (
    .clk(clk), .rst(rst), .ck(ck), .data(data), .rd(rd), .clr_ovf(clr_ovf),
    .out(out_l), .valid(valid_l), .full(full_l), .count(count_l), .overflow(ovf_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ck = 1'b0;
    rd = 1'b0;
    clr_ovf = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic cap(input logic [3:0] v);
    data = v;
    ck = 1'b1;
    step();
    ck = 1'b0;
    step();
  endtask

  initial begin
    logic [3:0] exp_seq [4];
    checks = 0;
    failures = 0;
    data = '0;
    do_reset();

    // Reset state
    check("rst_count", 32'(count_d), 32'd0);
    check("rst_valid", 32'(valid_d), 32'd0);
    check("rst_full", 32'(full_d), 32'd0);
    check("rst_ovf", 32'(ovf_d), 32'd0);
    check("rst_out", 32'(out_d), 32'd0);

    // Single capture then pop
    data = 4'hA;
    ck = 1'b1;
    step();
    check("cap_valid", 32'(valid_d), 32'd1);
    check("cap_out", 32'(out_d), 32'hA);
    check("cap_count", 32'(count_d), 32'd1);
    ck = 1'b0;
    step();
    rd = 1'b1;
    step();
    check("pop_valid", 32'(valid_d), 32'd0);
    check("pop_out", 32'(out_d), 32'd0);
    step();
    check("rd_empty_count", 32'(count_d), 32'd0);
    rd = 1'b0;

    // ck held high: one capture in edge mode, one per cycle in level mode
    data = 4'h3;
    ck = 1'b1;
    for (int i = 0; i < 5; i++) step();
    ck = 1'b0;
    step();
    check("hold_count", 32'(count_d), 32'd1);
    check("hold_out", 32'(out_d), 32'h3);
    check("lvl_count", 32'(count_l), 32'd4);
    check("lvl_full", 32'(full_l), 32'd1);
    check("lvl_ovf", 32'(ovf_l), 32'd1);

    // Five captures into depth 4: drop vs overwrite
    do_reset();
    for (int i = 1; i <= 5; i++) cap(4'(i));
    check("drop_full", 32'(full_d), 32'd1);
    check("drop_ovf", 32'(ovf_d), 32'd1);
    check("drop_count", 32'(count_d), 32'd4);
    check("ow_count", 32'(count_o), 32'd4);
    check("ow_ovf", 32'(ovf_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("drop_pop", 32'(out_d), 32'(i + 1));
      check("ow_pop", 32'(out_o), 32'(i + 2));
      rd = 1'b1;
      step();
      rd = 1'b0;
    end
    check("drop_empty", 32'(valid_d), 32'd0);
    check("ow_empty", 32'(valid_o), 32'd0);

    // Full buffer: simultaneous capture and pop, overflow set/clear priority
    do_reset();
    for (int i = 1; i <= 4; i++) cap(4'(i));
    check("fill_ovf", 32'(ovf_d), 32'd0);
    cap(4'h5);
    check("full_drop_ovf", 32'(ovf_d), 32'd1);
    check("full_drop_head", 32'(out_d), 32'd1);
    data = 4'h7;
    ck = 1'b1;
    rd = 1'b1;
    step();
    check("sim_count", 32'(count_d), 32'd4);
    check("sim_head", 32'(out_d), 32'd2);
    ck = 1'b0;
    rd = 1'b0;
    step();
    data = 4'h9;
    ck = 1'b1;
    clr_ovf = 1'b1;
    step();
    check("set_beats_clr", 32'(ovf_d), 32'd1);
    check("set_beats_clr_cnt", 32'(count_d), 32'd4);
    ck = 1'b0;
    clr_ovf = 1'b0;
    step();
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("clr_ovf", 32'(ovf_d), 32'd0);
    exp_seq[0] = 4'h2;
    exp_seq[1] = 4'h3;
    exp_seq[2] = 4'h4;
    exp_seq[3] = 4'h7;
    for (int i = 0; i < 4; i++) begin
      check("sim_pop", 32'(out_d), 32'(exp_seq[i]));
      rd = 1'b1;
      step();
      rd = 1'b0;
    end
    check("sim_empty", 32'(valid_d), 32'd0);

    // Mid-cycle reset with ck held high across release
    do_reset();
    for (int i = 1; i <= 3; i++) cap(4'(i));
    check("pre_rst_count", 32'(count_d), 32'd3);
    @(negedge clk);
    rst = 1'b0;
    ck = 1'b1;
    data = 4'h6;
    #1;
    check("async_count", 32'(count_d), 32'd0);
    check("async_valid", 32'(valid_d), 32'd0);
    check("async_out", 32'(out_d), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("no_cap_after_rst", 32'(count_d), 32'd0);
    ck = 1'b0;
    step();
    ck = 1'b1;
    step();
    check("rearm_count", 32'(count_d), 32'd1);
    check("rearm_out", 32'(out_d), 32'h6);
    ck = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
